// File: rtl/wdt_heartbeat_gen_if.sv
// Signal bundle between the heartbeat generator and its surroundings.
// master drives the request/strobe side, slave is the generator itself.
interface wdt_heartbeat_gen_if #(
   parameter int unsigned MISS_CNT_W = 8
);
   logic                  enable;
   logic                  alive;
   logic                  wdt_irq;
   logic                  fault_clr;
   logic                  kick;
   logic                  fault;
   logic                  window_end;
   logic [MISS_CNT_W-1:0] miss_count;

   modport master (
      output enable, alive, wdt_irq, fault_clr,
      input  kick, fault, window_end, miss_count
   );

   modport slave (
      input  enable, alive, wdt_irq, fault_clr,
      output kick, fault, window_end, miss_count
   );
endinterface

// File: rtl/wdt_heartbeat_gen.sv
// Watchdog kick generator: kicks once per PERIOD only if the task strobed alive.
// Optional missed-window counter enabled by macro HB_MISS_COUNTER_EN.
module wdt_heartbeat_gen #(
   parameter int unsigned PERIOD      = 16,
   parameter int unsigned PULSE_WIDTH = 2,
   parameter int unsigned MISS_CNT_W  = 8
) (
   input  logic               clk,
   input  logic               rst,
   wdt_heartbeat_gen_if.slave bus
);
   localparam int unsigned     CNT_W     = $clog2(PERIOD);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PERIOD - 1);
   localparam logic [CNT_W-1:0] KICK_LAST = CNT_W'(PULSE_WIDTH - 1);

   typedef enum logic [1:0] {IDLE, WINDOW, KICK, FAULT} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             alive_seen_q, alive_seen_d;
   logic             kick_q, kick_d;
   logic             fault_q, fault_d;
   logic             window_end_q, window_end_d;
`ifdef HB_MISS_COUNTER_EN
   logic [MISS_CNT_W-1:0] miss_count_q, miss_count_d;
`endif

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      alive_seen_d = alive_seen_q;
      kick_d       = kick_q;
      fault_d      = fault_q;
      window_end_d = 1'b0;
`ifdef HB_MISS_COUNTER_EN
      miss_count_d = miss_count_q;
`endif
      if (bus.wdt_irq) begin
         state_d      = FAULT;
         kick_d       = 1'b0;
         fault_d      = 1'b1;
         cnt_d        = '0;
         alive_seen_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               kick_d       = 1'b0;
               cnt_d        = '0;
               alive_seen_d = 1'b0;
               if (bus.enable) state_d = WINDOW;
            end
            WINDOW, KICK: begin
               if (!bus.enable) begin
                  state_d      = IDLE;
                  kick_d       = 1'b0;
                  cnt_d        = '0;
                  alive_seen_d = 1'b0;
               end else if (cnt_q == CNT_LAST) begin
                  // The boundary cycle's own alive strobe still counts for this window.
                  cnt_d        = '0;
                  window_end_d = 1'b1;
                  alive_seen_d = 1'b0;
                  if (alive_seen_q || bus.alive) begin
                     state_d = KICK;
                     kick_d  = 1'b1;
                  end else begin
                     state_d = WINDOW;
                     kick_d  = 1'b0;
`ifdef HB_MISS_COUNTER_EN
                     if (miss_count_q != '1) miss_count_d = miss_count_q + 1'b1;
`endif
                  end
               end else begin
                  cnt_d        = cnt_q + CNT_W'(1);
                  alive_seen_d = alive_seen_q | bus.alive;
                  // KICK is entered with cnt=0, so cnt doubles as the pulse timer.
                  if (state_q == KICK && cnt_q == KICK_LAST) begin
                     state_d = WINDOW;
                     kick_d  = 1'b0;
                  end
               end
            end
            FAULT: begin
               if (bus.fault_clr) begin
                  state_d = IDLE;
                  fault_d = 1'b0;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         alive_seen_q <= 1'b0;
         kick_q       <= 1'b0;
         fault_q      <= 1'b0;
         window_end_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         alive_seen_q <= alive_seen_d;
         kick_q       <= kick_d;
         fault_q      <= fault_d;
         window_end_q <= window_end_d;
      end
   end

`ifdef HB_MISS_COUNTER_EN
   always_ff @(posedge clk) begin
      if (rst) miss_count_q <= '0;
      else     miss_count_q <= miss_count_d;
   end

   assign bus.miss_count = miss_count_q;
`else
   assign bus.miss_count = '0;
`endif

   assign bus.kick       = kick_q;
   assign bus.fault      = fault_q;
   assign bus.window_end = window_end_q;
endmodule

// File: tb/tb_wdt_heartbeat_gen.sv
// Self-checking bench for wdt_heartbeat_gen: a cycle model pushes expected
// outputs into a scoreboard queue, popped and compared after each edge.
module tb_wdt_heartbeat_gen;
   localparam int unsigned P  = 16;
   localparam int unsigned PW = 2;
   localparam int unsigned MW = 2;
   localparam int          MISS_MAX = (1 << MW) - 1;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   wdt_heartbeat_gen_if #(.MISS_CNT_W(MW)) bus ();

   wdt_heartbeat_gen #(
      .PERIOD      (P),
      .PULSE_WIDTH (PW),
      .MISS_CNT_W  (MW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      int kick;
      int fault;
      int window_end;
      int miss;
   } exp_t;

   exp_t exp_q[$];
   int   rise_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   cyc      = 0;
   int   prev_kick = 0;

   // reference model: mode 0 idle, 1 running, 2 fault
   int m_mode = 0, m_pos = 0, m_seen = 0, m_kick_left = 0, m_miss = 0;
   int m_kick = 0, m_fault = 0, m_we = 0;

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
   endtask

   function void model_step();
      int hit;
      if (rst) begin
         m_mode = 0; m_pos = 0; m_seen = 0; m_kick_left = 0; m_miss = 0;
         m_kick = 0; m_fault = 0; m_we = 0;
      end else if (bus.wdt_irq) begin
         m_mode = 2; m_pos = 0; m_seen = 0; m_kick_left = 0;
         m_kick = 0; m_fault = 1; m_we = 0;
      end else if (m_mode == 0) begin
         m_we = 0; m_kick = 0; m_pos = 0; m_seen = 0;
         if (bus.enable) m_mode = 1;
      end else if (m_mode == 2) begin
         m_we = 0;
         if (bus.fault_clr) begin m_mode = 0; m_fault = 0; end
      end else if (!bus.enable) begin
         m_mode = 0; m_pos = 0; m_seen = 0; m_kick_left = 0;
         m_kick = 0; m_we = 0;
      end else begin
         hit = m_seen | int'(bus.alive);
         if (m_pos == P - 1) begin
            m_we = 1; m_pos = 0; m_seen = 0;
            if (hit != 0) m_kick_left = PW;
            else begin
               m_kick_left = 0;
               if (m_miss < MISS_MAX) m_miss++;
            end
         end else begin
            m_we = 0; m_pos++; m_seen = hit;
            if (m_kick_left > 0) m_kick_left--;
         end
         m_kick = (m_kick_left > 0) ? 1 : 0;
      end
   endfunction

   task automatic cycle();
      exp_t e;
      model_step();
      e.kick = m_kick; e.fault = m_fault; e.window_end = m_we;
`ifdef HB_MISS_COUNTER_EN
      e.miss = m_miss;
`else
      e.miss = 0;
`endif
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      cyc++;
      e = exp_q.pop_front();
      check_eq("kick",       int'(bus.kick),       e.kick);
      check_eq("fault",      int'(bus.fault),      e.fault);
      check_eq("window_end", int'(bus.window_end), e.window_end);
      check_eq("miss_count", int'(bus.miss_count), e.miss);
      if (bus.kick && prev_kick == 0) rise_q.push_back(cyc);
      prev_kick = int'(bus.kick);
   endtask

   task automatic run(input int n);
      repeat (n) cycle();
   endtask

   task automatic run_alive(input int n);
      for (int i = 0; i < n; i++) begin
         bus.alive = (i % 10 == 0);
         cycle();
      end
      bus.alive = 1'b0;
   endtask

   task automatic wait_we(input string tag);
      int k = 0;
      while (!bus.window_end && k < 40) begin cycle(); k++; end
      if (!bus.window_end) check_eq(tag, int'(bus.window_end), 1);
   endtask

   task automatic wait_kick(input string tag);
      int k = 0;
      while (!bus.kick && k < 40) begin cycle(); k++; end
      if (!bus.kick) check_eq(tag, int'(bus.kick), 1);
   endtask

   int en_cyc, w, clr_cyc;
   int exp_miss;

   initial begin
`ifdef HB_MISS_COUNTER_EN
      exp_miss = 3;
`else
      exp_miss = 0;
`endif
      rst = 1'b1;
      bus.enable = 1'b0; bus.alive = 1'b0; bus.wdt_irq = 1'b0; bus.fault_clr = 1'b0;
      run(2);
      rst = 1'b0;

      // reset held two cycles while a kick is in progress
      bus.enable = 1'b1; bus.alive = 1'b1;
      wait_kick("tmo_kick_pre_rst");
      bus.alive = 1'b0;
      rst = 1'b1;
      run(2);
      rst = 1'b0;
      check_eq("rst_kick",  int'(bus.kick), 0);
      check_eq("rst_fault", int'(bus.fault), 0);
      check_eq("rst_we",    int'(bus.window_end), 0);
      check_eq("rst_miss",  int'(bus.miss_count), 0);

      // steady heartbeat: first kick PERIOD after enable, then every PERIOD
      rise_q.delete();
      en_cyc = cyc + 1;
      run_alive(60);
      check_eq("hb_rises",       rise_q.size(), 3);
      check_eq("hb_first_lat",   rise_q[0] - en_cyc, 16);
      check_eq("hb_period",      rise_q[1] - rise_q[0], 16);

      // three silent windows, then resume
      wait_we("tmo_we_miss");
      w = cyc;
      rise_q.delete();
      run(48);
      check_eq("miss_no_kick", rise_q.size(), 0);
      check_eq("miss_count3",  int'(bus.miss_count), exp_miss);
      bus.alive = 1'b1;
      cycle();
      bus.alive = 1'b0;
      run(15);
      check_eq("resume_rises", rise_q.size(), 1);
      check_eq("resume_at",    rise_q[0] - w, 64);

      // alive only on the last cycle of the window
      wait_we("tmo_we_last");
      run(15);
      bus.alive = 1'b1;
      cycle();
      bus.alive = 1'b0;
      check_eq("last_cycle_kick", int'(bus.kick), 1);

      // saturation: five misses on a 2-bit counter
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      run(16 * 5 + 2);
      check_eq("miss_sat", int'(bus.miss_count), exp_miss);

      // watchdog interrupt mid-kick, fault latching and clearing
      bus.alive = 1'b1;
      wait_kick("tmo_kick_irq");
      bus.wdt_irq = 1'b1;
      cycle();
      bus.wdt_irq = 1'b0;
      check_eq("irq_kick",  int'(bus.kick), 0);
      check_eq("irq_fault", int'(bus.fault), 1);
      run(20);
      bus.alive = 1'b0;
      check_eq("fault_hold", int'(bus.fault), 1);
      bus.fault_clr = 1'b1; bus.wdt_irq = 1'b1;
      cycle();
      check_eq("clr_vs_irq", int'(bus.fault), 1);
      bus.wdt_irq = 1'b0;
      cycle();
      bus.fault_clr = 1'b0;
      check_eq("clr_fault", int'(bus.fault), 0);
      clr_cyc = cyc;
      rise_q.delete();
      run_alive(40);
      check_eq("clr_first_lat", rise_q[0] - clr_cyc, 17);

      // enable dropped mid-window, then restarted
      wait_we("tmo_we_en");
      run(7);
      bus.enable = 1'b0;
      cycle();
      check_eq("dis_kick", int'(bus.kick), 0);
      run(3);
      bus.enable = 1'b1;
      en_cyc = cyc + 1;
      rise_q.delete();
      run_alive(40);
      check_eq("reen_first_lat", rise_q[0] - en_cyc, 16);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
